// File: rtl/pipelined_shifter_if.sv
// Request/response bundle for the pipelined shifter: operand, shift amount,
// op and tag on the request side, result and tag on the response side, each
// with its own valid/ready pair.
interface pipelined_shifter_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    // Producer of requests / consumer of results
    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // The shifter itself
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator. A shift of 0..WIDTH-1 is split into
// log2(WIDTH) conditional power-of-two stages, largest first, with a register
// rank after each stage. The whole pipeline freezes while the result at the
// head is valid but not accepted, so bubbles are kept in place.
module pipelined_shifter #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst,
    pipelined_shifter_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;

    // Stage k register holds the operation after the 2^k step has been applied.
    // Its shamt field keeps the bits below k that later stages still consume.
    logic               valid_q [SHAMT_W];
    logic [WIDTH-1:0]   data_q  [SHAMT_W];
    logic [1:0]         op_q    [SHAMT_W];
    logic [TAG_W-1:0]   tag_q   [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_q [SHAMT_W];

    logic               valid_d [SHAMT_W];
    logic [WIDTH-1:0]   data_d  [SHAMT_W];
    logic [1:0]         op_d    [SHAMT_W];
    logic [TAG_W-1:0]   tag_d   [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_d [SHAMT_W];

    // Source of stage k is entry k+1; the top entry is the request port.
    logic               src_valid [SHAMT_W+1];
    logic [WIDTH-1:0]   src_data  [SHAMT_W+1];
    logic [1:0]         src_op    [SHAMT_W+1];
    logic [TAG_W-1:0]   src_tag   [SHAMT_W+1];
    logic [SHAMT_W-1:0] src_shamt [SHAMT_W+1];

    logic [2*WIDTH-1:0] dbl;
    logic               stall;

    assign stall         = valid_q[0] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = valid_q[0];
    assign bus.out_data  = data_q[0];
    assign bus.out_tag   = tag_q[0];

    assign src_valid[SHAMT_W] = bus.in_valid;
    assign src_data[SHAMT_W]  = bus.in_data;
    assign src_op[SHAMT_W]    = bus.in_op;
    assign src_tag[SHAMT_W]   = bus.in_tag;
    assign src_shamt[SHAMT_W] = bus.in_shamt;

    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_src
        assign src_valid[gi] = valid_q[gi];
        assign src_data[gi]  = data_q[gi];
        assign src_op[gi]    = op_q[gi];
        assign src_tag[gi]   = tag_q[gi];
        assign src_shamt[gi] = shamt_q[gi];
    end

    // Each stage conditionally shifts/rotates its source by 2^k and retires shamt bit k
    always_comb begin
        dbl = '0;
        for (int k = 0; k < SHAMT_W; k++) begin
            valid_d[k]    = src_valid[k+1];
            op_d[k]       = src_op[k+1];
            tag_d[k]      = src_tag[k+1];
            shamt_d[k]    = src_shamt[k+1];
            shamt_d[k][k] = 1'b0;
            data_d[k]     = src_data[k+1];
            // Doubled word: a rotate is just a WIDTH-bit window into it.
            dbl = {src_data[k+1], src_data[k+1]};
            if (src_shamt[k+1][k]) begin
                case (src_op[k+1])
                    OP_ROL:  data_d[k] = dbl[2*WIDTH-1-(1 << k) -: WIDTH];
                    OP_SLL:  data_d[k] = src_data[k+1] << (1 << k);
                    OP_ROR:  data_d[k] = dbl[WIDTH-1+(1 << k) -: WIDTH];
                    default: data_d[k] = src_data[k+1] >> (1 << k);
                endcase
            end
        end
    end

    // Stage registers: cleared by reset, frozen as a whole on stall, else advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                op_q[k]    <= '0;
                tag_q[k]   <= '0;
                shamt_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                valid_q[k] <= valid_d[k];
                data_q[k]  <= data_d[k];
                op_q[k]    <= op_d[k];
                tag_q[k]   <= tag_d[k];
                shamt_q[k] <= shamt_d[k];
            end
        end
    end
endmodule
